// File: rtl/div_16bit_sched.sv
// Round-robin scheduler sharing one fixed-latency 16-bit divider core among NUM_REQ requesters.
// Divide-by-zero jobs are answered locally without starting the core.
module div_16bit_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned DIV_LATENCY = 36
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic                    div_start,
  output logic [15:0]             div_a,
  output logic [15:0]             div_b,
  input  logic [15:0]             div_result,
  input  logic [15:0]             div_odd,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [15:0]             rsp_quot,
  output logic [15:0]             rsp_rem,
  output logic                    rsp_dbz,
  output logic                    busy
);

  localparam int unsigned CNT_W = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             div_start_d, busy_d, rsp_valid_d, rsp_dbz_d;
  logic [15:0]      div_a_d, div_b_d, rsp_quot_d, rsp_rem_d;
  logic [ID_W-1:0]  rsp_id_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [15:0]      a_sel, b_sel;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    a_sel       = '0;
    b_sel       = '0;
    cand        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && cand == i && req_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'(i);
          a_sel       = req_a[16*i +: 16];
          b_sel       = req_b[16*i +: 16];
        end
      end
    end
  end

  // Accept strobe is combinational and only ever raised while idle.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && grant_found && (grant_idx == ID_W'(i));
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    div_a_d    = div_a;
    div_b_d    = div_b;
    rsp_id_d   = rsp_id;
    rsp_quot_d = rsp_quot;
    rsp_rem_d  = rsp_rem;
    rsp_dbz_d  = rsp_dbz;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          last_d   = grant_idx;
          rsp_id_d = grant_idx;
          if (b_sel == 16'h0000) begin
            rsp_quot_d = 16'hFFFF;
            rsp_rem_d  = a_sel;
            rsp_dbz_d  = 1'b1;
            state_d    = RESP;
          end else begin
            div_a_d = a_sel;
            div_b_d = b_sel;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(DIV_LATENCY - 1)) begin
          rsp_quot_d = div_result;
          rsp_rem_d  = div_odd;
          rsp_dbz_d  = 1'b0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    div_start_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= ID_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_quot  <= '0;
      rsp_rem   <= '0;
      rsp_dbz   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      div_start <= div_start_d;
      div_a     <= div_a_d;
      div_b     <= div_b_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_quot  <= rsp_quot_d;
      rsp_rem   <= rsp_rem_d;
      rsp_dbz   <= rsp_dbz_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_div_16bit_sched.sv
// Bench for div_16bit_sched: job-level reference model with cycle-exact handshake expectations,
// a fixed-latency divider core model, directed cases and randomized traffic.
module tb_div_16bit_sched;

  localparam int N = 4;
  localparam int L = 36;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_ready;
  logic [16*N-1:0] req_a, req_b;
  logic          div_start;
  logic [15:0]   div_a, div_b, div_result, div_odd;
  logic          rsp_valid, rsp_ready, rsp_dbz, busy;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_quot, rsp_rem;

  div_16bit_sched #(.NUM_REQ(N), .ID_W(2), .DIV_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .div_odd(div_odd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_dbz(rsp_dbz), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider core: result is correct only in the cycle it is due, garbage otherwise.
  logic [15:0] core_q, core_r;
  int          core_cnt;
  always @(posedge clk) begin
    if (reset) core_cnt <= L;
    else if (div_start) begin
      core_q   <= (div_b == 0) ? 16'hFFFF : div_a / div_b;
      core_r   <= (div_b == 0) ? div_a : div_a % div_b;
      core_cnt <= 0;
    end else if (core_cnt < L) core_cnt <= core_cnt + 1;
  end
  assign div_result = (core_cnt == L - 1) ? core_q : ~core_q;
  assign div_odd    = (core_cnt == L - 1) ? core_r : ~core_r;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state: at most one job in flight.
  bit          outstanding = 0;
  bit          prev_rst = 0;
  int          ptr = N - 1;
  logic [1:0]  j_id;
  logic [15:0] j_a, j_b, j_q, j_r;
  logic        j_dbz;
  int          j_gcyc, j_rcyc;
  int          grant_cnt[N];
  int          grant_log[$];
  int          rsp_cnt = 0, start_cnt = 0;
  logic [1:0]  last_id;
  logic [15:0] last_q, last_r;
  logic        last_dbz;
  int          last_lat;

  // Compare process: evaluates each cycle once inputs have settled, then advances the model.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic         exp_start, exp_rv;
    int           g;
    #1;
    cyc++;
    if (prev_rst) begin
      chk("reset_ctrl", {div_start, rsp_valid, busy, rsp_dbz, rsp_id}, 64'h0);
      chk("reset_data", {div_a, div_b, rsp_quot, rsp_rem}, 64'h0);
    end
    prev_rst = reset;
    if (reset) begin
      outstanding = 0;
      ptr = N - 1;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (!outstanding) begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, outstanding);
      exp_start = outstanding && !j_dbz && (cyc == j_gcyc + 1);
      chk("div_start", div_start, exp_start);
      if (exp_start) chk("div_operands", {div_a, div_b}, {j_a, j_b});
      if (div_start) start_cnt++;
      exp_rv = outstanding && (cyc >= j_rcyc);
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) chk("rsp_payload", {rsp_id, rsp_quot, rsp_rem, rsp_dbz}, {j_id, j_q, j_r, j_dbz});
      if (exp_rv && rsp_ready) begin
        outstanding = 0;
        rsp_cnt++;
        last_id = rsp_id; last_q = rsp_quot; last_r = rsp_rem; last_dbz = rsp_dbz;
        last_lat = cyc - j_gcyc;
      end else if (g >= 0) begin
        outstanding = 1;
        j_id   = 2'(g);
        j_a    = req_a[16*g +: 16];
        j_b    = req_b[16*g +: 16];
        j_dbz  = (j_b == 0);
        j_q    = j_dbz ? 16'hFFFF : j_a / j_b;
        j_r    = j_dbz ? j_a : j_a % j_b;
        j_gcyc = cyc;
        j_rcyc = j_dbz ? cyc + 1 : cyc + L + 2;
        ptr    = g;
        grant_cnt[g]++;
        grant_log.push_back(g);
      end
    end
  end

  task automatic raise(input int i, input logic [15:0] a, input logic [15:0] b);
    req_valid[i] = 1'b1;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic wait_grant(input int i, input int old);
    int n = 0;
    while (grant_cnt[i] == old && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk("grant_timeout", grant_cnt[i], old + 1);
    req_valid[i] = 1'b0;
  endtask

  task automatic submit(input int i, input logic [15:0] a, input logic [15:0] b);
    int old;
    @(negedge clk);
    old = grant_cnt[i];
    raise(i, a, b);
    wait_grant(i, old);
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk("rsp_timeout", rsp_cnt, target);
  endtask

  task automatic drain();
    int n = 0;
    while (outstanding && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk("drain_timeout", outstanding, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic job(input int i, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] q, input logic [15:0] r, input logic dbz, input int lat);
    int r0, s0;
    r0 = rsp_cnt;
    s0 = start_cnt;
    submit(i, a, b);
    wait_rsp(r0 + 1);
    chk("job_result", {last_id, last_q, last_r, last_dbz}, {2'(i), q, r, dbz});
    chk("job_latency", last_lat, lat);
    chk("job_starts", start_cnt - s0, dbz ? 0 : 1);
  endtask

  initial begin
    int seen[N];
    int r0, n, gsz;
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Basic divide, divide-by-zero, and boundary operands.
    job(0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, L + 2);
    job(1, 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);
    job(0, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, L + 2);
    job(3, 16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, L + 2);

    // All requesters valid continuously from reset: rotation order.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) raise(i, 16'(i * 1000 + 5), 16'(i + 3));
    n = 0;
    while (grant_log.size() < 5 && n < 400) begin @(negedge clk); n++; end
    req_valid = '0;
    chk("rr_count", grant_log.size(), 5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("rr_order", grant_log[k], k % N);
    drain();

    // Back-pressure in RESP: held response, no new grant.
    rsp_ready = 1'b0;
    submit(2, 16'd500, 16'd3);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    raise(3, 16'd77, 16'd0);
    gsz = grant_log.size();
    r0 = rsp_cnt;
    repeat (10) @(negedge clk);
    chk("hold_grants", grant_log.size(), gsz);
    chk("hold_payload", {rsp_valid, rsp_id, rsp_quot, rsp_rem}, {1'b1, 2'd2, 16'd166, 16'd2});
    chk("hold_rsp_cnt", rsp_cnt, r0);
    rsp_ready = 1'b1;
    wait_grant(3, grant_cnt[3]);
    wait_rsp(r0 + 2);
    chk("dbz_after_hold", {last_id, last_q, last_r, last_dbz}, {2'd3, 16'hFFFF, 16'd77, 1'b1});

    // Reset in the middle of WAIT: job discarded, later job still correct.
    r0 = start_cnt;
    submit(1, 16'd40000, 16'd7);
    n = 0;
    while (start_cnt == r0 && n < 50) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    do_reset();
    r0 = rsp_cnt;
    repeat (60) @(negedge clk);
    chk("no_stale_rsp", {rsp_cnt, 31'(rsp_valid)}, {r0, 31'd0});
    job(2, 16'd65535, 16'd255, 16'd257, 16'd0, 1'b0, L + 2);

    // Randomized traffic with random back-pressure and operand mix.
    for (int i = 0; i < N; i++) seen[i] = grant_cnt[i];
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (grant_cnt[i] != seen[i]) begin
          seen[i] = grant_cnt[i];
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i] && ($urandom % 8) == 0) begin
          case ($urandom % 6)
            0:       raise(i, 16'($urandom), 16'd0);
            1:       raise(i, 16'($urandom), 16'd1);
            2:       raise(i, 16'($urandom), 16'($urandom % 16));
            default: raise(i, 16'($urandom), 16'($urandom));
          endcase
        end else if (req_valid[i] && ($urandom % 50) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = (($urandom % 4) != 0);
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();
    chk("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
